// File: rtl/mb_scan_pkg.sv
// Shared types and constants for the block scanner.
package mb_scan_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef logic [15:0] coord_t;
  localparam int MB_SIZE     = 16;
  localparam int BLK_DEFAULT = 4;
endpackage

// File: rtl/mb_zscan_map.sv
// Maps a 4x4 block index inside a 16x16 macroblock to its pixel offsets in H.264 z-scan order.
module mb_zscan_map
  import mb_scan_pkg::*;
(
  input  logic [3:0] blk_idx,
  output coord_t     row_off,
  output coord_t     col_off
);
  assign row_off = {11'd0, blk_idx[3], blk_idx[1], 2'b00};
  assign col_off = {11'd0, blk_idx[2], blk_idx[0], 2'b00};
endmodule

// File: rtl/mb_scanner.sv
// Frame block-coordinate generator with valid/ready handshake; raster order by default,
// H.264 z-scan order inside 16x16 macroblocks when MB_SCANNER_ZSCAN_EN is defined.
module mb_scanner
  import mb_scan_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int LENGTH = 720,
  parameter int BLK    = BLK_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] mbnumber,
  output logic        last,
  output logic        busy,
  output logic        done
);
  localparam coord_t COL_LAST = coord_t'(WIDTH - BLK);
  localparam coord_t ROW_LAST = coord_t'(LENGTH - BLK);

  state_t state_q, state_d;
  coord_t row_q, row_d, col_q, col_d;
  logic   valid_q, valid_d, last_q, last_d, busy_q, busy_d, done_q, done_d;
  logic   xfer;

`ifdef MB_SCANNER_ZSCAN_EN
  localparam coord_t MB_STEP     = coord_t'(MB_SIZE);
  localparam coord_t MB_COL_LAST = coord_t'(WIDTH - MB_SIZE);

  coord_t     mb_row_q, mb_row_d, mb_col_q, mb_col_d, row_off, col_off;
  logic [3:0] blk_q, blk_d, blk_nxt;

  // Offsets are looked up for the block that follows the current one.
  assign blk_nxt = blk_q + 4'd1;
  mb_zscan_map u_map (
    .blk_idx (blk_nxt),
    .row_off (row_off),
    .col_off (col_off)
  );
`else
  localparam coord_t STEP = coord_t'(BLK);
`endif

  assign xfer = enable & valid_q & ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MB_SCANNER_ZSCAN_EN
    mb_row_d = mb_row_q;
    mb_col_d = mb_col_q;
    blk_d    = blk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && enable) begin
          state_d = S_RUN;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
`ifdef MB_SCANNER_ZSCAN_EN
          mb_row_d = '0;
          mb_col_d = '0;
          blk_d    = '0;
`endif
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (last_q) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
`ifdef MB_SCANNER_ZSCAN_EN
            blk_d = blk_nxt;
            if (blk_q == 4'hf) begin
              if (mb_col_q == MB_COL_LAST) begin
                mb_col_d = '0;
                mb_row_d = mb_row_q + MB_STEP;
              end else begin
                mb_col_d = mb_col_q + MB_STEP;
              end
            end
            row_d = mb_row_d + row_off;
            col_d = mb_col_d + col_off;
`else
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + STEP;
            end else begin
              col_d = col_q + STEP;
            end
`endif
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // last is registered alongside the coordinate it describes.
    last_d = valid_d && (row_d == ROW_LAST) && (col_d == COL_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MB_SCANNER_ZSCAN_EN
      mb_row_q <= '0;
      mb_col_q <= '0;
      blk_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MB_SCANNER_ZSCAN_EN
      mb_row_q <= mb_row_d;
      mb_col_q <= mb_col_d;
      blk_q    <= blk_d;
`endif
    end
  end

  assign valid    = valid_q & enable;
  assign mbnumber = {row_q, col_q};
  assign last     = last_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_mb_scanner.sv
// Scoreboard bench for mb_scanner: small-frame handshake scenarios plus a full default frame.
module tb_mb_scanner;
`ifdef MB_SCANNER_ZSCAN_EN
  localparam int SW = 32;
  localparam int SL = 16;
`else
  localparam int SW = 16;
  localparam int SL = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_start, s_enable, s_ready, s_valid, s_last, s_busy, s_done;
  logic [31:0] s_mb;
  logic        f_start, f_enable, f_ready, f_valid, f_last, f_busy, f_done;
  logic [31:0] f_mb;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mb_scanner #(.WIDTH(SW), .LENGTH(SL), .BLK(4)) dut_s (
    .clk(clk), .reset(rst), .enable(s_enable), .start(s_start), .ready(s_ready),
    .valid(s_valid), .mbnumber(s_mb), .last(s_last), .busy(s_busy), .done(s_done)
  );

  mb_scanner dut_f (
    .clk(clk), .reset(rst), .enable(f_enable), .start(f_start), .ready(f_ready),
    .valid(f_valid), .mbnumber(f_mb), .last(f_last), .busy(f_busy), .done(f_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input int w, input int l);
`ifdef MB_SCANNER_ZSCAN_EN
    for (int mr = 0; mr < l; mr += 16)
      for (int mc = 0; mc < w; mc += 16)
        for (int b = 0; b < 16; b++) begin
          int r, c;
          r = mr + ((b >> 3) & 1) * 8 + ((b >> 1) & 1) * 4;
          c = mc + ((b >> 2) & 1) * 8 + (b & 1) * 4;
          exp_q.push_back({r[15:0], c[15:0]});
        end
`else
    for (int r = 0; r < l; r += 4)
      for (int c = 0; c < w; c += 4)
        exp_q.push_back({r[15:0], c[15:0]});
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; s_start = 1'b1; s_enable = 1'b1; s_ready = 1'b1;
    f_start = 1'b0; f_enable = 1'b1; f_ready = 1'b1;
    tick(); tick();
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", s_valid); end
    total++; if (s_mb !== 32'h0) begin bad++; $display("FAIL reset_mb got=%h want=0", s_mb); end
    total++; if (s_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", s_last); end
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", s_busy); end
    total++; if (s_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", s_done); end
    rst = 1'b0; s_start = 1'b0;
    tick();
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL reset_no_start got=%b want=0", s_busy); end
  endtask

  task automatic test_frame();
    int n = 0;
    int cyc = 0;
    logic [31:0] e;
    logic [31:0] got[64];
    push_model(SW, SL);
    s_enable = 1'b1; s_ready = 1'b1; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    while (exp_q.size() != 0 && cyc < 100) begin
      #1;
      if (s_valid) begin
        e = exp_q.pop_front();
        got[n] = s_mb; n++;
        total++; if (s_mb !== e) begin bad++; $display("FAIL frame_mb got=%h want=%h", s_mb, e); end
        total++; if (s_last !== (exp_q.size() == 0)) begin bad++; $display("FAIL frame_last got=%b at %h", s_last, s_mb); end
      end
      tick(); cyc++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL frame_timeout left=%0d want=0", exp_q.size()); exp_q.delete(); end
    total++; if (s_done !== 1'b1) begin bad++; $display("FAIL frame_done got=%b want=1", s_done); end
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL frame_valid_after got=%b want=0", s_valid); end
`ifdef MB_SCANNER_ZSCAN_EN
    total++; if (got[2] !== 32'h0004_0000) begin bad++; $display("FAIL z_beat2 got=%h want=00040000", got[2]); end
    total++; if (got[3] !== 32'h0004_0004) begin bad++; $display("FAIL z_beat3 got=%h want=00040004", got[3]); end
    total++; if (got[4] !== 32'h0000_0008) begin bad++; $display("FAIL z_beat4 got=%h want=00000008", got[4]); end
    total++; if (got[5] !== 32'h0000_000C) begin bad++; $display("FAIL z_beat5 got=%h want=0000000c", got[5]); end
    total++; if (got[16] !== 32'h0000_0010) begin bad++; $display("FAIL z_beat16 got=%h want=00000010", got[16]); end
    total++; if (got[31] !== 32'h000C_001C) begin bad++; $display("FAIL z_final got=%h want=000c001c", got[31]); end
`else
    total++; if (got[4] !== 32'h0004_0000) begin bad++; $display("FAIL r_beat4 got=%h want=00040000", got[4]); end
    total++; if (got[7] !== 32'h0004_000C) begin bad++; $display("FAIL r_final got=%h want=0004000c", got[7]); end
`endif
    tick();
    total++; if (s_done !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b want=0", s_done); end
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL busy_after got=%b want=0", s_busy); end
  endtask

  task automatic test_ready_stall();
    int popped = 0;
    int stalls = 0;
    int cyc = 0;
    logic [31:0] e;
    push_model(SW, SL);
    s_enable = 1'b1; s_ready = 1'b1; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    while (exp_q.size() != 0 && cyc < 100) begin
      if (popped == 2 && stalls < 3) begin
        s_ready = 1'b0;
        #1;
        total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", s_valid); end
        total++; if (s_mb !== 32'h0000_0008) begin bad++; $display("FAIL stall_mb got=%h want=00000008", s_mb); end
        stalls++;
      end else begin
        s_ready = 1'b1;
        #1;
        if (s_valid) begin
          e = exp_q.pop_front(); popped++;
          total++; if (s_mb !== e) begin bad++; $display("FAIL stall_seq got=%h want=%h", s_mb, e); end
        end
      end
      tick(); cyc++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_timeout left=%0d want=0", exp_q.size()); exp_q.delete(); end
    total++; if (s_done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b want=1", s_done); end
    tick();
  endtask

  task automatic test_enable_stall();
    int popped = 0;
    int lows = 0;
    int cyc = 0;
    logic [31:0] e;
    push_model(SW, SL);
    s_enable = 1'b1; s_ready = 1'b1; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    while (exp_q.size() != 0 && cyc < 100) begin
      if (popped == 3 && lows < 2) begin
        s_enable = 1'b0;
        #1;
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL en_low_valid got=%b want=0", s_valid); end
        total++; if (s_busy !== 1'b1) begin bad++; $display("FAIL en_low_busy got=%b want=1", s_busy); end
        lows++;
      end else begin
        s_enable = 1'b1;
        #1;
        if (s_valid) begin
          e = exp_q.pop_front(); popped++;
          total++; if (s_mb !== e) begin bad++; $display("FAIL en_seq got=%h want=%h", s_mb, e); end
        end
      end
      tick(); cyc++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL en_timeout left=%0d want=0", exp_q.size()); exp_q.delete(); end
    total++; if (s_done !== 1'b1) begin bad++; $display("FAIL en_done got=%b want=1", s_done); end
    tick();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int cyc = 0;
    f_enable = 1'b1; f_ready = 1'b1; f_start = 1'b1;
    tick();
    f_start = 1'b0;
    while (n < 10 && cyc < 50) begin
      #1;
      if (f_valid) begin
        total++; if (f_mb !== {16'd0, 16'(4 * n)}) begin bad++; $display("FAIL mid_seq got=%h want=%h", f_mb, {16'd0, 16'(4 * n)}); end
        n++;
      end
      tick(); cyc++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", f_valid); end
    total++; if (f_mb !== 32'h0) begin bad++; $display("FAIL mid_rst_mb got=%h want=0", f_mb); end
    total++; if (f_last !== 1'b0) begin bad++; $display("FAIL mid_rst_last got=%b want=0", f_last); end
    total++; if (f_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", f_busy); end
    total++; if (f_done !== 1'b0) begin bad++; $display("FAIL mid_rst_done got=%b want=0", f_done); end
    tick(); tick();
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL mid_no_resume got=%b want=0", f_valid); end
    f_start = 1'b1;
    tick();
    f_start = 1'b0;
    total++; if (f_valid !== 1'b1) begin bad++; $display("FAIL restart_valid got=%b want=1", f_valid); end
    total++; if (f_mb !== 32'h0) begin bad++; $display("FAIL restart_mb0 got=%h want=0", f_mb); end
    tick();
    total++; if (f_mb !== 32'h0000_0004) begin bad++; $display("FAIL restart_mb1 got=%h want=00000004", f_mb); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    int cnt = 0;
    int lasts = 0;
    int cyc = 0;
    int r = 0;
    int c = 0;
    int maxr = 0;
    int maxc = 0;
    logic [31:0] last_mb = '0;
    f_enable = 1'b1; f_ready = 1'b1; f_start = 1'b1;
    tick();
    f_start = 1'b0;
    while (!f_done && cyc < 60000) begin
      #1;
      if (f_valid) begin
        total++;
        if (f_mb !== {r[15:0], c[15:0]}) begin
          bad++;
          if (bad < 20) $display("FAIL full_seq got=%h want=%h", f_mb, {r[15:0], c[15:0]});
        end
        if (int'(f_mb[31:16]) > maxr) maxr = int'(f_mb[31:16]);
        if (int'(f_mb[15:0]) > maxc) maxc = int'(f_mb[15:0]);
        if (f_last) begin lasts++; last_mb = f_mb; end
        cnt++;
        c += 4;
        if (c == 1280) begin c = 0; r += 4; end
      end
      tick(); cyc++;
    end
    total++; if (f_done !== 1'b1) begin bad++; $display("FAIL full_timeout done=%b want=1", f_done); end
    total++; if (cnt != 57600) begin bad++; $display("FAIL full_count got=%0d want=57600", cnt); end
    total++; if (maxr != 716) begin bad++; $display("FAIL full_maxrow got=%0d want=716", maxr); end
    total++; if (maxc != 1276) begin bad++; $display("FAIL full_maxcol got=%0d want=1276", maxc); end
    total++; if (lasts != 1) begin bad++; $display("FAIL full_last_count got=%0d want=1", lasts); end
    total++; if (last_mb !== 32'h02CC_04FC) begin bad++; $display("FAIL full_last_mb got=%h want=02cc04fc", last_mb); end
  endtask

  initial begin
    test_reset();
    test_frame();
`ifndef MB_SCANNER_ZSCAN_EN
    test_ready_stall();
    test_enable_stall();
    test_reset_mid();
    test_full_frame();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mb_scanner.md
MB_SCANNER -- requirements
Module: mb_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 1280, frame width in pixels.
REQ-002 SHALL have parameter LENGTH, default 720, frame height in pixels.
REQ-003 SHALL have parameter BLK, default 4, block edge in pixels.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  global advance enable.
REQ-007 SHALL have port start  input  1  begin one frame scan.
REQ-008 SHALL have port ready  input  1  downstream (intraloop) accepts the current block.
REQ-009 SHALL have port valid  output  1  mbnumber holds a valid block coordinate.
REQ-010 SHALL have port mbnumber  output  32  {row[15:0], col[15:0]}, pixel coordinates of the block's top-left corner.
REQ-011 SHALL have port last  output  1  current beat is the final block of the frame.
REQ-012 SHALL have port busy  output  1  scan in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at frame end.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE.
REQ-015 SHALL move IDLE->RUN on start&enable, loading row=0, col=0, and asserting valid on the next cycle.
REQ-016 SHALL define a transfer as enable&valid&ready, and on each transfer SHALL advance to the next block.
REQ-017 SHALL hold mbnumber and last stable while valid&~(enable&ready).
REQ-018 SHALL gate valid to 0 while enable=0 and freeze all state, without losing or repeating any block.
REQ-019 In raster order, SHALL advance col by BLK; when col=WIDTH-BLK, SHALL set col=0 and row+=BLK.
REQ-020 SHALL emit rows 0..LENGTH-BLK only; no beat with row>=LENGTH or col>=WIDTH.
REQ-021 SHALL assert last exactly when row=LENGTH-BLK and col=WIDTH-BLK under raster order.
REQ-022 On the transfer with last=1, SHALL go RUN->DONE, deassert valid, and pulse done=1 for one cycle, then return to IDLE.
REQ-023 SHALL ignore start in RUN and DONE.
REQ-024 SHALL assert busy in RUN and DONE.
REQ-025 SHALL emit (WIDTH/BLK)*(LENGTH/BLK) beats per frame (57600 at defaults).
REQ-026 SHALL treat row/col as unsigned 16-bit values, with no wrap within legal parameters.

Reset
REQ-027 When reset=1 at posedge, SHALL enter IDLE with valid=0, mbnumber=0, last=0, busy=0, done=0, overriding start and any in-flight scan.
REQ-028 SHALL require a fresh start after reset to begin a scan; reset mid-frame SHALL NOT resume.

Configuration
REQ-029 With macro MB_SCANNER_ZSCAN_EN defined, SHALL use H.264 z-scan order: 16x16 macroblocks in raster order, and the 16 4x4 blocks inside each macroblock visited by index b[3:0], with col offset = {b[2],b[0]}*4 and row offset = {b[3],b[1]}*4.
REQ-030 With MB_SCANNER_ZSCAN_EN defined, SHALL require BLK=4 and WIDTH, LENGTH to be multiples of 16, and SHALL assert last at the final block of the last macroblock (row=LENGTH-4, col=WIDTH-4).
REQ-031 Without MB_SCANNER_ZSCAN_EN, SHALL use raster order per REQ-019, with no z-scan logic present.

Structure
REQ-032 Package mb_scan_pkg SHALL hold the state enum, coordinate typedef (16-bit), MB_SIZE=16 and default BLK.
REQ-033 Sub-module mb_zscan_map SHALL map 4-bit block index to {row,col} offsets; it SHALL be instantiated only under MB_SCANNER_ZSCAN_EN.

Verification
REQ-034 Bench SHALL run WIDTH=16, LENGTH=8, raster, ready=1, start pulse -> beats (0,0),(0,4),(0,8),(0,12),(4,0)..(4,12); last on (4,12); done pulse one cycle later.
REQ-035 Bench SHALL drive ready low 3 cycles at beat (0,8) -> mbnumber stays 0x00000008 with valid=1; next beat is 0x0000000C.
REQ-036 Bench SHALL drive enable low 2 cycles mid-frame -> valid=0 and no beat skipped or repeated.
REQ-037 Bench SHALL run z-scan with WIDTH=32, LENGTH=16 -> first six beats (0,0),(0,4),(4,0),(4,4),(0,8),(0,12); beat 17 is (0,16); last on (12,28).
REQ-038 Bench SHALL assert reset at beat 10, then start -> outputs zero the cycle after reset, and the scan restarts at (0,0).
REQ-039 Bench SHALL run defaults full frame -> exactly 57600 transfers, with max row=716 and max col=1276.
